full_adder: RTL and testbench
=============================

FULL_ADDER -- requirements
Module: full_adder

Interface
REQ-001 Parameter WIDTH, default 1: operand width in bits; legal range 1..64.
REQ-002 Parameter OUT_REG, default 1: 1 = registered outputs; 0 = combinational outputs (clk/rst_n unused).
REQ-003 clk  input  1  sole clock; rising-edge active.
REQ-004 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 a  input  WIDTH  addend A, unsigned.
REQ-006 b  input  WIDTH  addend B, unsigned.
REQ-007 c_in  input  1  carry-in.
REQ-008 sum  output  WIDTH  low WIDTH bits of a + b + c_in.
REQ-009 c_out  output  1  carry-out, bit WIDTH of a + b + c_in.

Function
REQ-010 The block SHALL compute {c_out, sum} = a + b + c_in as an unsigned (WIDTH+1)-bit result; no truncation other than the split into sum and c_out.
REQ-011 The datapath SHALL be a ripple chain of 1-bit full-adder cells: s_i = a_i ^ b_i ^ c_i; c_(i+1) = (a_i & b_i) | (c_i & (a_i ^ b_i)); c_0 = c_in; c_out = c_WIDTH.
REQ-012 With OUT_REG=1, sum and c_out SHALL be registered; latency is exactly one clk cycle from input sampling to output update.
REQ-013 With OUT_REG=1, inputs sampled at rising edge N SHALL appear on sum/c_out immediately after edge N, and hold until edge N+1.
REQ-014 With OUT_REG=0, sum and c_out SHALL follow the inputs combinationally with zero cycle latency.
REQ-015 Throughput SHALL be one new operand set per cycle, with no handshake and no stall.
REQ-016 Boundary: all-ones a and b with c_in=1 SHALL yield sum = all-ones, c_out=1, with no overflow beyond c_out.
REQ-017 Boundary: all-zero inputs with c_in=0 SHALL yield sum=0, c_out=0.
REQ-018 Input changes between clock edges SHALL NOT affect registered outputs (OUT_REG=1).
REQ-019 Unknown (X) on any input bit SHALL NOT be masked by the logic; it propagates per gate semantics.

Reset
REQ-020 While rst_n=0 and OUT_REG=1, sum SHALL be 0 and c_out SHALL be 0, immediately and regardless of clk.
REQ-021 Reset deassertion SHALL be synchronised to clk internally, so the first register update occurs on the first rising edge after rst_n is sampled high.
REQ-022 Reset asserted mid-stream SHALL clear outputs at once; no pending result is kept after reset.
REQ-023 With OUT_REG=0, rst_n SHALL have no effect on the outputs.

Verification
REQ-024 WIDTH=1, OUT_REG=1: drive each (a,b,c_in) from 000 to 111 on consecutive edges -> one cycle later, (c_out,sum) = 00, 01, 01, 10, 01, 10, 10, 11 respectively.
REQ-025 Reset: hold rst_n=0 with a=b=c_in=1 while toggling clk -> sum=0, c_out=0 throughout; release rst_n -> first post-release edge yields sum=1, c_out=1.
REQ-026 Mid-stream reset: assert rst_n=0 between edges while sum=1 -> sum and c_out go to 0 without waiting for a clock edge.
REQ-027 WIDTH=8: a=8'hFF, b=8'h01, c_in=0 -> sum=8'h00, c_out=1; a=8'hFF, b=8'hFF, c_in=1 -> sum=8'hFF, c_out=1.
REQ-028 Random: 10+ cycles of random a, b, c_in -> every output pair matches a + b + c_in sampled one cycle earlier; with OUT_REG=0, it matches in the same cycle.
REQ-029 Hold: keep inputs constant for 3 cycles, then change them mid-cycle -> registered outputs change only at the next rising edge.

Source files
------------

// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
//   Unsigned WIDTH-bit ripple-carry adder: {c_out, sum} = a + b + c_in.
//   The datapath is a chain of 1-bit full-adder cells (fa_cell), instantiated
//   as an array with the carry vector threading from cell i into cell i+1.
//   With OUT_REG=1 the result is registered (one-cycle latency, async clear).
//   With OUT_REG=0 it is purely combinational and clk/rst_n are ignored.
//
// Ports
//   clk    in   1      rising-edge clock (OUT_REG=1 only)
//   rst_n  in   1      async active-low clear of sum/c_out (OUT_REG=1 only)
//   a      in   WIDTH  addend A, unsigned
//   b      in   WIDTH  addend B, unsigned
//   c_in   in   1      carry-in
//   sum    out  WIDTH  low WIDTH bits of a + b + c_in
//   c_out  out  1      bit WIDTH of a + b + c_in
// -----------------------------------------------------------------------------

// One bit of the ripple chain. Plain gate expressions so an X on any input
// propagates exactly as the gates would, with no masking.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic co
);
    logic p;

    assign p  = a ^ b;
    assign s  = p ^ c;
    assign co = (a & b) | (c & p);
endmodule

module full_adder #(
    parameter int WIDTH   = 1,   // 1..64
    parameter int OUT_REG = 1    // 1: registered outputs, 0: combinational
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);
    // carry[i] is the carry into cell i; carry[WIDTH] is the final carry-out.
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_c;

    assign carry[0] = c_in;

    // Instance array: each cell gets one bit of a/b/carry-in and drives one
    // bit of sum and the next carry.
    fa_cell u_cell [WIDTH-1:0] (
        .a  (a),
        .b  (b),
        .c  (carry[WIDTH-1:0]),
        .s  (sum_c),
        .co (carry[WIDTH:1])
    );

    generate
        if (OUT_REG != 0) begin : g_reg
            logic [WIDTH-1:0] sum_q;
            logic             c_out_q;

            // Assertion clears at once. Release takes effect only through a
            // clock edge: the first rising edge that sees rst_n high loads the
            // adder result, so nothing computed before or during reset survives.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sum_q   <= '0;
                    c_out_q <= 1'b0;
                end else begin
                    sum_q   <= sum_c;
                    c_out_q <= carry[WIDTH];
                end
            end

            assign sum   = sum_q;
            assign c_out = c_out_q;
        end else begin : g_comb
            // Clock and reset have no role in the combinational build.
            logic unused_clk_rst;
            assign unused_clk_rst = &{1'b0, clk, rst_n};

            assign sum   = sum_c;
            assign c_out = carry[WIDTH];
        end
    endgenerate
endmodule

// File: tb/tb_full_adder.sv
// -----------------------------------------------------------------------------
// tb_full_adder
//   Three instances: 1-bit registered, 8-bit registered, 8-bit combinational
//   (the combinational one shares the 8-bit operands). Expected sums are
//   computed with plain integer addition and pushed to a queue per registered
//   instance when operands are driven; they are popped and compared one clock
//   edge later. The combinational instance is compared right after driving.
// -----------------------------------------------------------------------------
module tb_full_adder;
    logic       clk;
    logic       rst_n;
    logic       a1, b1, c1;
    logic [7:0] a8, b8;
    logic       c8;
    logic       sum1, c_out1;
    logic [7:0] sum8, sumc;
    logic       c_out8, c_outc;

    int n_chk;
    int n_err;

    logic [1:0] q1[$];
    logic [8:0] q8[$];
    logic [1:0] last1;
    logic [8:0] last8;

    full_adder #(.WIDTH(1), .OUT_REG(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .c_in(c1),
        .sum(sum1), .c_out(c_out1)
    );

    full_adder #(.WIDTH(8), .OUT_REG(1)) dut8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .c_in(c8),
        .sum(sum8), .c_out(c_out8)
    );

    full_adder #(.WIDTH(8), .OUT_REG(0)) dutc (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .c_in(c8),
        .sum(sumc), .c_out(c_outc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [8:0] add8(input logic [7:0] x, input logic [7:0] y, input logic c);
        return 9'(x) + 9'(y) + 9'(c);
    endfunction

    // Drive one operand set mid-cycle, confirm registered outputs still hold
    // the previous result, then compare after the next rising edge.
    task automatic step(input logic a1v, input logic b1v, input logic c1v,
                        input logic [7:0] a8v, input logic [7:0] b8v, input logic c8v);
        logic [1:0] e1;
        logic [8:0] e8;
        a1 = a1v; b1 = b1v; c1 = c1v;
        a8 = a8v; b8 = b8v; c8 = c8v;
        q1.push_back(2'(a1v) + 2'(b1v) + 2'(c1v));
        q8.push_back(add8(a8v, b8v, c8v));
        #1;
        chk("hold1", 64'({c_out1, sum1}), 64'(last1));
        chk("hold8", 64'({c_out8, sum8}), 64'(last8));
        chk("comb8", 64'({c_outc, sumc}), 64'(add8(a8v, b8v, c8v)));
        @(posedge clk);
        #1;
        if (q1.size() == 0 || q8.size() == 0) begin
            chk("sb_empty", 64'(q1.size() + q8.size()), 64'd2);
        end else begin
            e1 = q1.pop_front();
            e8 = q8.pop_front();
            chk("reg1", 64'({c_out1, sum1}), 64'(e1));
            chk("reg8", 64'({c_out8, sum8}), 64'(e8));
            last1 = e1;
            last8 = e8;
        end
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        last1 = '0;
        last8 = '0;
        rst_n = 1'b0;
        a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
        a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;

        // Held in reset with all-ones operands: outputs stay zero on every edge,
        // combinational instance unaffected.
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("rst1", 64'({c_out1, sum1}), 64'd0);
            chk("rst8", 64'({c_out8, sum8}), 64'd0);
            chk("rst_comb", 64'({c_outc, sumc}), 64'h1FF);
        end

        // Release between edges; first edge afterwards loads 1+1+1 / FF+FF+1.
        #2 rst_n = 1'b1;
        step(1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1);

        // Exhaustive 1-bit truth table on consecutive edges.
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            step(v[2], v[1], v[0], 8'(i * 37), 8'(255 - i * 11), v[0]);
        end

        // 8-bit boundaries.
        step(1'b0, 1'b0, 1'b0, 8'hFF, 8'h01, 1'b0);
        step(1'b0, 1'b0, 1'b0, 8'hFF, 8'hFF, 1'b1);
        step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        step(1'b1, 1'b0, 1'b1, 8'h80, 8'h80, 1'b0);
        step(1'b0, 1'b1, 1'b0, 8'h7F, 8'h00, 1'b1);

        // Random back-to-back operands.
        for (int i = 0; i < 20; i++) begin
            step(1'($urandom), 1'($urandom), 1'($urandom),
                 8'($urandom), 8'($urandom), 1'($urandom));
        end

        // Hold constant for three cycles, then the next step changes them mid-cycle.
        repeat (3) step(1'b1, 1'b0, 1'b0, 8'h5A, 8'hA5, 1'b0);
        step(1'b0, 1'b1, 1'b1, 8'h12, 8'h34, 1'b1);

        // Mid-stream reset while sum1=1: clears without a clock edge.
        step(1'b1, 1'b0, 1'b0, 8'hC3, 8'h3C, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst1", 64'({c_out1, sum1}), 64'd0);
        chk("midrst8", 64'({c_out8, sum8}), 64'd0);
        chk("midrst_comb", 64'({c_outc, sumc}), 64'(add8(8'hC3, 8'h3C, 1'b1)));
        a1 = 1'b1; b1 = 1'b1; c1 = 1'b0;
        a8 = 8'h0F; b8 = 8'hF0; c8 = 1'b0;
        @(posedge clk);
        #1;
        chk("inrst1", 64'({c_out1, sum1}), 64'd0);
        chk("inrst8", 64'({c_out8, sum8}), 64'd0);
        last1 = '0;
        last8 = '0;
        #2 rst_n = 1'b1;
        step(1'b0, 1'b1, 1'b0, 8'h01, 8'h02, 1'b1);
        step(1'b1, 1'b1, 1'b0, 8'hAA, 8'h55, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
